// File: rtl/sll_seq.sv
// Multi-cycle shift-left-logical unit: shifts a held register left by up to STEP bits per clock.
// Optional SLL_SEQ_FAST_EN: b=0 and b>=WIDTH complete straight from IDLE with latency 1.
module sll_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             busy,
   output logic             done
);

   localparam int               CW      = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
   localparam logic [WIDTH-1:0] B_LIM   = WIDTH'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;

   logic             w_b_big;
   logic             w_fast;
   logic [CW-1:0]    w_cnt_init;
   logic [CW-1:0]    w_k;
   logic [CW-1:0]    w_cnt_next;
   logic [WIDTH-1:0] w_shreg_next;

   // Any amount with bits above the count range saturates to WIDTH, which shifts everything out.
   assign w_b_big      = (b >= B_LIM);
   assign w_cnt_init   = w_b_big ? CNT_MAX : b[CW-1:0];
   assign w_k          = (r_cnt < STEP_C) ? r_cnt : STEP_C;
   assign w_shreg_next = r_shreg << w_k;
   assign w_cnt_next   = r_cnt - w_k;

`ifdef SLL_SEQ_FAST_EN
   assign w_fast = start && ((b == '0) || w_b_big);
`else
   assign w_fast = 1'b0;
`endif

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fast) begin
                  r_state <= S_DONE;
                  r_shreg <= w_b_big ? '0 : a;
                  r_res   <= w_b_big ? '0 : a;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
               end else if (start) begin
                  r_state <= S_SHIFT;
                  r_shreg <= a;
                  r_cnt   <= w_cnt_init;
                  r_busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               r_shreg <= w_shreg_next;
               r_cnt   <= w_cnt_next;
               // A zero count on entry falls through here too: k=0, so the result is unchanged.
               if (w_cnt_next == '0) begin
                  r_state <= S_DONE;
                  r_res   <= w_shreg_next;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign res  = r_res;
   assign busy = r_busy;
   assign done = r_done;

endmodule
